// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide unit:
// operation encodings, sequencer states, iteration count, helpers.
package mips_muldiv_pkg;

    localparam int N_ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'h0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the 64-bit shift/add (multiply) or restoring
// shift/subtract (divide) datapath.
// Ports: div_mode selects divide; acc_i/acc_o current/next
// accumulator; opd_i multiplicand or divisor magnitude.
module muldiv_step
    import mips_muldiv_pkg::*;
(
    input  logic        div_mode,
    input  logic [63:0] acc_i,
    input  logic [31:0] opd_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        sum    = {1'b0, acc_i[63:32]}
               + {1'b0, (acc_i[0] ? opd_i : 32'h0)};
        // Divide: acc = {remainder, dividend/quotient bits}.
        // rem_sh is the remainder after shifting in the next bit.
        rem_sh = acc_i[63:31];
        diff   = rem_sh - {1'b0, opd_i};
        if (div_mode) begin
            if (!diff[32]) begin
                acc_o = {diff[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {rem_sh[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// MIPS multiply/divide unit with HI/LO registers, fixed 34-cycle latency.
// Ports: clk, reset (async high); start/op/a/b request; mthi/mtlo
// write a into HI/LO in idle; busy, done pulse, hi, lo outputs.
module mips_muldiv
    import mips_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LAST = 5'(N_ITER - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opd_q, opd_d;
    logic [31:0] a_q, a_d;
    op_e         op_q, op_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        bz_q, bz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [63:0] step_acc;
    logic        is_signed;
    logic [31:0] ma, mb;
    logic [31:0] q_fix, r_fix;

    muldiv_step u_step (
        .div_mode (op_q[1]),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        a_d       = a_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        bz_d      = bz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        q_fix     = acc_q[31:0];
        r_fix     = acc_q[63:32];
        is_signed = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
        ma        = is_signed ? abs32(a) : a;
        mb        = is_signed ? abs32(b) : b;

        unique case (state_q)
            S_IDLE: begin
                // The done cycle blocks both start and mthi/mtlo.
                if (!done_q) begin
                    if (start) begin
                        op_d    = op_e'(op);
                        a_d     = a;
                        sa_d    = is_signed & a[31];
                        sb_d    = is_signed & b[31];
                        bz_d    = (b == 32'h0);
                        cnt_d   = 5'd0;
                        state_d = S_ITER;
                        if (op[1]) begin
                            opd_d = mb;
                            acc_d = {32'h0, ma};
                        end else begin
                            opd_d = ma;
                            acc_d = {32'h0, mb};
                        end
                    end else begin
                        if (mthi) hi_d = a;
                        if (mtlo) lo_d = a;
                    end
                end
            end
            S_ITER: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!op_q[1]) begin
                    if (sa_q ^ sb_q) acc_d = 64'h0 - acc_q;
                end else if (bz_q) begin
                    acc_d = {a_q, 32'hFFFF_FFFF};
                end else begin
                    // Quotient truncates to zero; remainder follows dividend.
                    if (sa_q ^ sb_q) q_fix = 32'h0 - acc_q[31:0];
                    if (sa_q) r_fix = 32'h0 - acc_q[63:32];
                    acc_d = {r_fix, q_fix};
                end
            end
            S_DONE: begin
                hi_d    = acc_q[63:32];
                lo_d    = acc_q[31:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'h0;
            opd_q   <= 32'h0;
            a_q     <= 32'h0;
            op_q    <= OP_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            a_q     <= a_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Testbench for mips_muldiv: directed and random operations
// against an arithmetic reference model of HI/LO.
module tb_mips_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vectors;
    int          miscompares;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mips_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_op(input logic [1:0] o,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
        longint      sx, sy, p, q, r;
        logic [63:0] ux, uy, res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        res = 64'h0;
        case (o)
            2'b00: begin
                p   = sx * sy;
                res = p;
            end
            2'b01: res = ux * uy;
            2'b10: begin
                if (y == 32'h0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the unit idle and done low.
    task automatic run_op(input logic [1:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y,
                          input bit pulses,
                          input bit with_mt);
        logic [63:0] exp;
        exp   = model_op(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        mthi  = with_mt;
        mtlo  = with_mt;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_e0", {62'h0, busy, done}, 64'h2);
        chk("hilo_e0", {hi, lo}, {m_hi, m_lo});
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if (k < 34) begin
                chk("busy_run", {62'h0, busy, done}, 64'h2);
                chk("hilo_hold", {hi, lo}, {m_hi, m_lo});
            end else begin
                chk("done_e34", {62'h0, busy, done}, 64'h1);
                chk("result", {hi, lo}, exp);
                m_hi = exp[63:32];
                m_lo = exp[31:0];
            end
            if (pulses) begin
                if (k == 5 || k == 20) begin
                    start = 1'b1;
                    op    = 2'($urandom);
                end
                if (k == 6 || k == 21) start = 1'b0;
                if (k == 10) begin
                    mthi = 1'b1;
                    mtlo = 1'b1;
                end
                if (k == 11) begin
                    mthi = 1'b0;
                    mtlo = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("idle_after", {62'h0, busy, done}, 64'h0);
        chk("hilo_after", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {62'h0, busy, done}, 64'h0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // mthi alone, then mtlo and mthi together
        a    = 32'h1234;
        mthi = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        m_hi = 32'h1234;
        chk("mthi", {hi, lo}, {m_hi, m_lo});
        a    = 32'hCAFE_F00D;
        mthi = 1'b1;
        mtlo = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        m_hi = 32'hCAFE_F00D;
        m_lo = 32'hCAFE_F00D;
        chk("mthi_mtlo", {hi, lo}, {m_hi, m_lo});

        // directed corner operations
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        chk("mult_min", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        chk("divu_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_wrap", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // start and mthi/mtlo pulses while busy are ignored
        run_op(2'b11, 32'd1000, 32'd7, 1'b1, 1'b0);
        // start with mthi/mtlo in the same idle cycle
        run_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b1);

        // reset in the middle of a divide
        start = 1'b1;
        op    = 2'b10;
        a     = $urandom;
        b     = 32'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        chk("rst_mid_flags", {62'h0, busy, done}, 64'h0);
        chk("rst_mid_hilo", {hi, lo}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_rst", {62'h0, busy, done}, 64'h0);
        end
        run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0);
        chk("multu_6x7", {hi, lo}, 64'd42);

        // random operations
        for (int i = 0; i < 40; i++) begin
            logic [31:0] rx, ry;
            rx = $urandom;
            ry = $urandom;
            if (i % 8 == 3) ry = 32'h0;
            if (i % 8 == 5) ry = ry >> ($urandom_range(31, 0));
            run_op(2'($urandom), rx, ry, bit'(i % 5 == 0), bit'(i % 7 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
